// File: rtl/sopc_run_ctrl.sv
// Run controller for an SOPC under test: holds all reset domains, releases them
// one by one, then times the run until halt, timeout or restart.
module sopc_run_ctrl #(
    parameter int unsigned NUM_DOMAINS    = 2,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50,
    parameter int unsigned AUTO_START     = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   halt_i,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic                   run_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_cnt_o
);

    localparam int unsigned PH_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned DOM_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  STAG_LAST = PH_W'(STAGGER_CYCLES - 1);
    localparam logic [DOM_W-1:0] DOM_LAST  = DOM_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam bit               AUTO_EN   = (AUTO_START != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic [DOM_W-1:0]        idx_q, idx_d;
    logic [NUM_DOMAINS-1:0]  dom_q, dom_d;
    logic                    run_q, run_d;
    logic                    done_q, done_d;
    logic                    to_q, to_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        run_d   = run_q;
        done_d  = done_q;
        to_d    = to_q;
        cnt_d   = cnt_q;

        if ((state_q != ST_IDLE) && start_i) begin
            // Restart outranks halt and timeout
            state_d = ST_HOLD;
            ph_d    = '0;
            idx_d   = '0;
            dom_d   = '1;
            run_d   = 1'b0;
            done_d  = 1'b0;
            to_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (AUTO_EN || start_i) begin
                        state_d = ST_HOLD;
                        ph_d    = '0;
                    end
                end
                ST_HOLD: begin
                    if (ph_q == HOLD_LAST) begin
                        dom_d[0] = 1'b0;
                        ph_d     = '0;
                        if (NUM_DOMAINS == 1) begin
                            state_d = ST_RUN;
                            run_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_STAGGER;
                            idx_d   = DOM_W'(1);
                        end
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                ST_STAGGER: begin
                    if (ph_q == STAG_LAST) begin
                        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx_q == DOM_W'(i)) dom_d[i] = 1'b0;
                        end
                        ph_d = '0;
                        if (idx_q == DOM_LAST) begin
                            state_d = ST_RUN;
                            run_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + DOM_W'(1);
                        end
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        dom_d   = '1;
                        to_d    = 1'b0;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        dom_d   = '1;
                        to_d    = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    dom_d   = '1;
                    run_d   = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset forces every domain back into reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            run_q   <= run_d;
            done_q  <= done_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dom_rst_o   = dom_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign timeout_o   = to_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: a schedule-based reference model feeds a scoreboard,
// plus fixed-value checks at the key edges of each scenario.
module tb_sopc_run_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_SEQ  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    typedef struct {
        int phase;
        int age;
        int cnt;
        bit to;
    } mstate_t;

    typedef struct {
        logic [7:0]  dom;
        logic        run;
        logic        done;
        logic        to;
        logic [15:0] cnt;
    } mout_t;

    typedef struct {
        mout_t a;
        mout_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [1:0]  dom0;
    logic        run0, done0, to0;
    logic [15:0] cnt0;
    logic [0:0]  dom1;
    logic        run1, done1, to1;
    logic [15:0] cnt1;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb_q[$];
    mstate_t m0, m1;

    sopc_run_ctrl dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i),
        .dom_rst_o(dom0), .run_o(run0), .done_o(done0),
        .timeout_o(to0), .cycle_cnt_o(cnt0)
    );

    sopc_run_ctrl #(.NUM_DOMAINS(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i),
        .dom_rst_o(dom1), .run_o(run1), .done_o(done1),
        .timeout_o(to1), .cycle_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic mstate_t model_reset();
        mstate_t s;
        s.phase = PH_IDLE; s.age = 0; s.cnt = 0; s.to = 1'b0;
        return s;
    endfunction

    // Release of domain k is scheduled at age H + k*S after HOLD entry
    function automatic mstate_t model_next(input mstate_t s, input int n, input int h,
                                           input int st, input int t, input bit strt, input bit hlt);
        mstate_t r = s;
        if (s.phase == PH_IDLE || strt) begin
            r.phase = PH_SEQ; r.age = 0; r.cnt = 0; r.to = 1'b0;
        end else if (s.phase == PH_SEQ) begin
            r.age = s.age + 1;
            if (r.age == h + (n - 1) * st) begin
                r.phase = PH_RUN; r.cnt = 0;
            end
        end else if (s.phase == PH_RUN) begin
            if (hlt) begin
                r.phase = PH_DONE; r.to = 1'b0;
            end else if (t > 0 && s.cnt == t - 1) begin
                r.phase = PH_DONE; r.to = 1'b1;
            end else if (s.cnt < 65535) begin
                r.cnt = s.cnt + 1;
            end
        end
        return r;
    endfunction

    function automatic mout_t model_out(input mstate_t s, input int n, input int h, input int st);
        mout_t o;
        o.dom = '0;
        for (int k = 0; k < n; k++) begin
            if (s.phase == PH_SEQ) o.dom[k] = (s.age < h + k * st);
            else if (s.phase != PH_RUN) o.dom[k] = 1'b1;
        end
        o.run  = (s.phase == PH_RUN);
        o.done = (s.phase == PH_DONE);
        o.to   = s.to;
        o.cnt  = 16'(s.cnt);
        return o;
    endfunction

    // One clock: predict, push, let the DUTs clock, pop and compare
    task automatic tick();
        exp_t e;
        m0 = model_next(m0, 2, 4, 2, 50, start_i, halt_i);
        m1 = model_next(m1, 1, 4, 2, 50, start_i, halt_i);
        e.a = model_out(m0, 2, 4, 2);
        e.b = model_out(m1, 1, 4, 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_dom0",  32'(dom0),  32'(e.a.dom));
        check("sb_run0",  32'(run0),  32'(e.a.run));
        check("sb_done0", 32'(done0), 32'(e.a.done));
        check("sb_to0",   32'(to0),   32'(e.a.to));
        check("sb_cnt0",  32'(cnt0),  32'(e.a.cnt));
        check("sb_dom1",  32'(dom1),  32'(e.b.dom));
        check("sb_run1",  32'(run1),  32'(e.b.run));
        check("sb_done1", 32'(done1), 32'(e.b.done));
        check("sb_to1",   32'(to1),   32'(e.b.to));
        check("sb_cnt1",  32'(cnt1),  32'(e.b.cnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the default-config model is running with the given count
    task automatic run_to(input int target);
        int g = 0;
        while (!(m0.phase == PH_RUN && m0.cnt == target) && g < 300) begin
            tick();
            g++;
        end
        if (g >= 300) begin
            n_chk++;
            n_err++;
            $display("FAIL run_to_%0d: no match after %0d cycles, required fewer than 300", target, g);
        end
    endtask

    initial begin
        m0 = model_reset();
        m1 = model_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_dom0", 32'(dom0), 32'h3);
        check("rst_run0", 32'(run0), 32'h0);
        check("rst_done0", 32'(done0), 32'h0);
        check("rst_to0", 32'(to0), 32'h0);
        check("rst_cnt0", 32'(cnt0), 32'h0);
        check("rst_dom1", 32'(dom1), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Power-up release with defaults
        tick();
        check("pu_e1_dom0", 32'(dom0), 32'h3);
        ticks(4);
        check("pu_e5_dom0", 32'(dom0), 32'h2);
        check("pu_e5_run1", 32'(run1), 32'h1);
        check("pu_e5_cnt1", 32'(cnt1), 32'h0);
        ticks(2);
        check("pu_e7_dom0", 32'(dom0), 32'h0);
        check("pu_e7_run0", 32'(run0), 32'h1);
        check("pu_e7_cnt0", 32'(cnt0), 32'h0);

        // Timeout after 50 run cycles
        run_to(49);
        tick();
        check("to_done", 32'(done0), 32'h1);
        check("to_flag", 32'(to0), 32'h1);
        check("to_dom", 32'(dom0), 32'h3);
        check("to_cnt", 32'(cnt0), 32'd49);
        ticks(3);
        check("to_auto_once", 32'(dom0), 32'h3);

        // Halt at count 10
        start_i = 1'b1; tick(); start_i = 1'b0;
        run_to(10);
        halt_i = 1'b1; tick(); halt_i = 1'b0;
        check("halt_done", 32'(done0), 32'h1);
        check("halt_to", 32'(to0), 32'h0);
        check("halt_cnt", 32'(cnt0), 32'd10);
        check("halt_dom", 32'(dom0), 32'h3);
        ticks(3);
        check("halt_freeze", 32'(cnt0), 32'd10);

        // Restart from RUN at count 20
        start_i = 1'b1; tick(); start_i = 1'b0;
        run_to(20);
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("rs_run", 32'(run0), 32'h0);
        check("rs_dom", 32'(dom0), 32'h3);
        check("rs_cnt", 32'(cnt0), 32'h0);
        ticks(4);
        check("rs_e4_dom", 32'(dom0), 32'h2);
        ticks(2);
        check("rs_e6_dom", 32'(dom0), 32'h0);
        check("rs_e6_run", 32'(run0), 32'h1);

        // Halt and timeout on the same edge
        run_to(49);
        halt_i = 1'b1; tick(); halt_i = 1'b0;
        check("ht_to", 32'(to0), 32'h0);
        check("ht_done", 32'(done0), 32'h1);
        check("ht_cnt", 32'(cnt0), 32'd49);

        // Start together with halt, from DONE and from RUN
        start_i = 1'b1; halt_i = 1'b1; tick(); start_i = 1'b0; halt_i = 1'b0;
        check("sh_done_done", 32'(done0), 32'h0);
        check("sh_done_dom", 32'(dom0), 32'h3);
        run_to(5);
        start_i = 1'b1; halt_i = 1'b1; tick(); start_i = 1'b0; halt_i = 1'b0;
        check("sh_run_done", 32'(done0), 32'h0);
        check("sh_run_run", 32'(run0), 32'h0);
        check("sh_run_cnt", 32'(cnt0), 32'h0);

        // Reset between edge 5 and edge 7 of a release sequence
        ticks(4);
        check("mr_e5_dom0", 32'(dom0), 32'h2);
        #3 rst = 1'b0;
        #1;
        check("mr_dom0", 32'(dom0), 32'h3);
        check("mr_run0", 32'(run0), 32'h0);
        check("mr_dom1", 32'(dom1), 32'h1);
        check("mr_run1", 32'(run1), 32'h0);
        m0 = model_reset();
        m1 = model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        check("mr_e1_dom0", 32'(dom0), 32'h3);
        ticks(4);
        check("mr_e5_run1", 32'(run1), 32'h1);
        check("mr_e5_dom0b", 32'(dom0), 32'h2);
        ticks(2);
        check("mr_e7_run0", 32'(run0), 32'h1);
        check("mr_e7_dom0", 32'(dom0), 32'h0);
        ticks(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
